// File: rtl/dffram_pkg.sv
// Shared constants and types for the DFFRAM OBI host bridge.
package dffram_pkg;

  localparam int unsigned WINDOW_BYTES  = 16384;
  localparam int          DFFRAM_ADDR_W = 12;

  typedef enum logic {
    PORT_INSTR = 1'b0,
    PORT_DATA  = 1'b1
  } port_e;

endpackage

// File: rtl/dffram_obi_host.sv
// Two-port OBI (fetch + load/store) front end for a single-port DFFRAM.
// Grants are combinational and round-robin; responses follow one cycle later.
module dffram_obi_host
  import dffram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ADDR_W    = DFFRAM_ADDR_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              instr_req_i,
  input  logic [31:0]       instr_addr_i,
  output logic              instr_gnt_o,
  output logic              instr_rvalid_o,
  output logic [31:0]       instr_rdata_o,
  output logic              instr_err_o,
  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [3:0]        data_be_i,
  input  logic [31:0]       data_addr_i,
  input  logic [31:0]       data_wdata_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  output logic [31:0]       data_rdata_o,
  output logic              data_err_o,
  output logic              ram_en_o,
  output logic [3:0]        ram_we_o,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic [31:0]       ram_di_o,
  input  logic [31:0]       ram_do_i
);

  port_e       last_winner;
  logic        both, pick_data, igt, dgt, gnt_any, addr_ok, store;
  logic [31:0] sel_addr, off;
  logic        i_vld, d_vld, rsp_err, rsp_rd;

  // Data wins uncontended requests and contention after an instr win.
  assign both      = instr_req_i & data_req_i;
  assign pick_data = data_req_i & (~instr_req_i | (last_winner == PORT_INSTR));
  assign dgt       = ~RST & pick_data;
  assign igt       = ~RST & instr_req_i & ~pick_data;
  assign gnt_any   = igt | dgt;

  // Unsigned offset: addresses below BASE_ADDR wrap high and fail the range check.
  assign sel_addr = dgt ? data_addr_i : instr_addr_i;
  assign off      = sel_addr - BASE_ADDR;
  assign addr_ok  = (off < 32'(WINDOW_BYTES)) && (off[1:0] == 2'b00);
  assign store    = dgt & data_we_i;

  assign instr_gnt_o = igt;
  assign data_gnt_o  = dgt;
  assign ram_en_o    = gnt_any & addr_ok;
  assign ram_we_o    = (ram_en_o & store) ? data_be_i : 4'b0000;
  assign ram_a_o     = off[ADDR_W+1:2];
  assign ram_di_o    = data_wdata_i;

  always_ff @(posedge CLK) begin
    if (RST) begin
      i_vld       <= 1'b0;
      d_vld       <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rd      <= 1'b0;
      last_winner <= PORT_INSTR;
    end else begin
      i_vld   <= igt;
      d_vld   <= dgt;
      rsp_err <= gnt_any & ~addr_ok;
      rsp_rd  <= ram_en_o & ~store;
      if (both) last_winner <= dgt ? PORT_DATA : PORT_INSTR;
    end
  end

  // Responses are masked while RST is high so a pending one never escapes.
  assign instr_rvalid_o = i_vld & ~RST;
  assign instr_err_o    = instr_rvalid_o & rsp_err;
  assign instr_rdata_o  = (instr_rvalid_o & rsp_rd) ? ram_do_i : 32'h0;
  assign data_rvalid_o  = d_vld & ~RST;
  assign data_err_o     = data_rvalid_o & rsp_err;
  assign data_rdata_o   = (data_rvalid_o & rsp_rd) ? ram_do_i : 32'h0;

endmodule
